alu_vec_pipe: RTL and testbench

Parametrised, pipelined successor of the 16-bit vector ALU lane. Processes LANES independent signed fixed-point lanes per transaction. Supports add, sub, correct signed fixed-point multiply, per-lane multiply-accumulate, optional saturation, and per-lane flags. Sits in the vector execute stage between the vector register-file read and writeback, with valid/ready handshakes on both sides.

---
 rtl/alu_vec_pipe.sv | 136 +++++++++++++
 tb/tb_alu_vec_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vec_pipe.sv
// LANES-wide signed fixed-point ALU (add/sub/mul/mac/aclr, optional saturation, per-lane VNZC flags).
// Two-cycle latency at one bundle per cycle; a stalled output holds stable and back-pressures S1, then in_ready.
module alu_vec_pipe #(
  parameter int LANES = 4,
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             opcode,
  input  logic                   sat_en,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES*4-1:0]     flags
);
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_MAC  = 3'b011;
  localparam logic [2:0] OP_ACLR = 3'b100;
  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic                   s1_valid;
  logic [2:0]             s1_op;
  logic                   s1_sat;
  logic [LANES*WIDTH-1:0] s1_a;
  logic [LANES*WIDTH-1:0] s1_b;
  logic                   s2_load;
  logic [WIDTH-1:0]       acc [LANES];
  logic [WIDTH-1:0]       nxt_acc [LANES];
  logic [LANES*WIDTH-1:0] nxt_result;
  logic [LANES*4-1:0]     nxt_flags;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_sat   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= opcode;
        s1_sat <= sat_en;
        s1_a   <= a;
        s1_b   <= b;
      end
    end
  end

  always_comb begin
    logic [WIDTH-1:0]   la, lb, lacc, mul_w, fin;
    logic [WIDTH:0]     ext, usum;
    logic [2*WIDTH-1:0] prod, prod_sh;
    logic               v, c, neg;
    nxt_result = '0;
    nxt_flags  = '0;
    for (int i = 0; i < LANES; i++) nxt_acc[i] = acc[i];
    for (int i = 0; i < LANES; i++) begin
      la      = s1_a[i*WIDTH +: WIDTH];
      lb      = s1_b[i*WIDTH +: WIDTH];
      lacc    = acc[i];
      // Sign-extended operands make the low 2*WIDTH bits the exact signed product.
      prod    = {{WIDTH{la[WIDTH-1]}}, la} * {{WIDTH{lb[WIDTH-1]}}, lb};
      prod_sh = $signed(prod) >>> FRAC;
      mul_w   = prod_sh[WIDTH-1:0];
      ext     = '0;
      usum    = {1'b0, la} + {1'b0, lb};
      v       = 1'b0;
      c       = 1'b0;
      neg     = 1'b0;
      fin     = '0;
      case (s1_op)
        OP_ADD: begin
          ext = {la[WIDTH-1], la} + {lb[WIDTH-1], lb};
          c   = usum[WIDTH];
          fin = usum[WIDTH-1:0];
        end
        OP_SUB: begin
          ext = {la[WIDTH-1], la} - {lb[WIDTH-1], lb};
          c   = la < lb;
          fin = ext[WIDTH-1:0];
        end
        OP_MUL: begin
          v   = !((&prod_sh[2*WIDTH-1:WIDTH-1]) || !(|prod_sh[2*WIDTH-1:WIDTH-1]));
          neg = prod_sh[2*WIDTH-1];
          fin = mul_w;
        end
        OP_MAC: begin
          ext = {lacc[WIDTH-1], lacc} + {mul_w[WIDTH-1], mul_w};
          fin = ext[WIDTH-1:0];
        end
        OP_ACLR: begin
          fin        = lacc;
          nxt_acc[i] = '0;
        end
        default: fin = '0;
      endcase
      if (s1_op == OP_ADD || s1_op == OP_SUB || s1_op == OP_MAC) begin
        v   = ext[WIDTH] ^ ext[WIDTH-1];
        neg = ext[WIDTH];
      end
      if (s1_sat && v) fin = neg ? S_MIN : S_MAX;
      if (s1_op == OP_MAC) nxt_acc[i] = fin;
      nxt_result[i*WIDTH +: WIDTH] = fin;
      nxt_flags[i*4 +: 4]          = {v, fin[WIDTH-1], fin == '0, c};
    end
  end

  // Accumulators move only with the S2 load, so a held output never re-applies its MAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= nxt_result;
        flags  <= nxt_flags;
        for (int i = 0; i < LANES; i++) acc[i] <= nxt_acc[i];
      end
    end
  end
endmodule

// File: tb/tb_alu_vec_pipe.sv
// Randomised and directed bench for alu_vec_pipe, scored against an integer reference model.
module tb_alu_vec_pipe;
  localparam int LANES = 4;
  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int LW    = LANES*WIDTH;
  localparam longint MAXV = (longint'(1) << (WIDTH-1)) - 1;
  localparam longint MINV = -(longint'(1) << (WIDTH-1));
  localparam longint MODV = longint'(1) << WIDTH;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      opcode = '0;
  logic            sat_en = 1'b0;
  logic [LW-1:0]   a = '0;
  logic [LW-1:0]   b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [LW-1:0]   result;
  logic [LANES*4-1:0] flags;

  alu_vec_pipe #(.LANES(LANES), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .sat_en(sat_en), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int in_count = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  longint macc [LANES];
  logic [LW-1:0]      exp_res_q [$];
  logic [LANES*4-1:0] exp_flg_q [$];
  logic [LW-1:0]      obs_res [$];
  logic [LANES*4-1:0] obs_flg [$];

  function automatic longint sx(longint u);
    return (u > MAXV) ? u - MODV : u;
  endfunction

  function automatic longint wrapv(longint v);
    longint r;
    r = v % MODV;
    if (r < 0) r += MODV;
    return sx(r);
  endfunction

  function automatic logic [LW-1:0] splat(input logic [15:0] v);
    return {LANES{v}};
  endfunction

  // Reference: exact integer arithmetic, then range check / clamp / wrap.
  task automatic ref_bundle(input logic [2:0] op, input logic sat, input logic [LW-1:0] av,
                            input logic [LW-1:0] bv, output logic [LW-1:0] res,
                            output logic [LANES*4-1:0] flg);
    longint ua, ub, sa, sb, full, r;
    logic [63:0] rb;
    logic v, c;
    res = '0;
    flg = '0;
    for (int i = 0; i < LANES; i++) begin
      ua = longint'(av[i*WIDTH +: WIDTH]);
      ub = longint'(bv[i*WIDTH +: WIDTH]);
      sa = sx(ua);
      sb = sx(ub);
      c = 1'b0;
      case (op)
        3'd0: begin full = sa + sb; c = (ua + ub) >= MODV; end
        3'd1: begin full = sa - sb; c = ua < ub; end
        3'd2: full = (sa * sb) >>> FRAC;
        3'd3: full = macc[i] + wrapv((sa * sb) >>> FRAC);
        3'd4: begin full = macc[i]; macc[i] = 0; end
        default: full = 0;
      endcase
      v = (full > MAXV) || (full < MINV);
      r = (sat && v) ? ((full > MAXV) ? MAXV : MINV) : wrapv(full);
      if (op == 3'd3) macc[i] = r;
      rb = r;
      res[i*WIDTH +: WIDTH] = rb[WIDTH-1:0];
      flg[i*4 +: 4] = {v, r < 0, r == 0, c};
    end
  endtask

  logic hold_vld = 1'b0;
  logic [LW-1:0] hold_res;
  logic [LANES*4-1:0] hold_flg;

  always @(negedge clk) begin
    logic [LW-1:0] er;
    logic [LANES*4-1:0] ef;
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        check("hold_valid", out_valid, 1);
        check("hold_result", result, hold_res);
        check("hold_flags", flags, hold_flg);
      end
      hold_vld = out_valid && !out_ready;
      hold_res = result;
      hold_flg = flags;
      if (out_valid && out_ready) begin
        check("sb_nonempty", exp_res_q.size() > 0, 1);
        if (exp_res_q.size() > 0) begin
          er = exp_res_q.pop_front();
          ef = exp_flg_q.pop_front();
          check("sb_result", result, er);
          check("sb_flags", flags, ef);
        end
        obs_res.push_back(result);
        obs_flg.push_back(flags);
      end
      if (in_valid && in_ready) begin
        ref_bundle(opcode, sat_en, a, b, er, ef);
        exp_res_q.push_back(er);
        exp_flg_q.push_back(ef);
        in_count++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [2:0] op, input logic s, input logic [LW-1:0] av,
                      input logic [LW-1:0] bv);
    int n = 0;
    opcode = op; sat_en = s; a = av; b = bv; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_res_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("drain", exp_res_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  bit rand_done = 1'b0;

  initial begin
    int lat;
    int base;
    for (int i = 0; i < LANES; i++) macc[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    send(3'd0, 1'b0, splat(16'h0003), splat(16'h0004));
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 10);
    check("add_latency", lat, 2);
    check("add_result", result, splat(16'h0007));
    check("add_flags", flags, 0);
    drain();

    obs_res.delete(); obs_flg.delete();
    send(3'd2, 1'b0, {16'h0000, 16'h4000, 16'hFF80, 16'h0180}, {16'h0000, 16'h0200, 16'h0100, 16'h0200});
    send(3'd2, 1'b1, {16'h0000, 16'h4000, 16'hFF80, 16'h0180}, {16'h0000, 16'h0200, 16'h0100, 16'h0200});
    send(3'd0, 1'b0, splat(16'h7FFF), splat(16'h0001));
    send(3'd0, 1'b1, splat(16'h7FFF), splat(16'h0001));
    send(3'd1, 1'b0, splat(16'h0000), splat(16'h0001));
    drain();
    check("mul_wrap_res", obs_res[0], {16'h0000, 16'h8000, 16'hFF80, 16'h0300});
    check("mul_wrap_flg", obs_flg[0], {4'b0010, 4'b1100, 4'b0100, 4'b0000});
    check("mul_sat_res", obs_res[1], {16'h0000, 16'h7FFF, 16'hFF80, 16'h0300});
    check("mul_sat_flg", obs_flg[1], {4'b0010, 4'b1000, 4'b0100, 4'b0000});
    check("add_ovf_res", obs_res[2], splat(16'h8000));
    check("add_ovf_flg", obs_flg[2], {LANES{4'b1100}});
    check("add_sat_res", obs_res[3], splat(16'h7FFF));
    check("add_sat_flg", obs_flg[3], {LANES{4'b1000}});
    check("sub_borrow_res", obs_res[4], splat(16'hFFFF));
    check("sub_borrow_flg", obs_flg[4], {LANES{4'b0101}});

    obs_res.delete(); obs_flg.delete();
    for (int k = 0; k < 3; k++) send(3'd3, 1'b0, splat(16'h0100), splat(16'h0200));
    send(3'd4, 1'b0, splat(16'h0000), splat(16'h0000));
    send(3'd3, 1'b0, splat(16'h0100), splat(16'h0200));
    drain();
    check("mac1", obs_res[0], splat(16'h0200));
    check("mac2", obs_res[1], splat(16'h0400));
    check("mac3", obs_res[2], splat(16'h0600));
    check("aclr", obs_res[3], splat(16'h0600));
    check("mac_after_clr", obs_res[4], splat(16'h0200));

    obs_res.delete(); obs_flg.delete();
    base = in_count;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(3'd3, 1'b0, splat(16'h0100), splat(16'h0100));
      end
      begin
        repeat (4) @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_accepted", in_count - base, 2);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", obs_res.size(), 6);
    for (int k = 0; k < 6; k++) check("bp_order", obs_res[k], splat(16'(16'h0300 + k*16'h0100)));

    out_ready = 1'b0;
    send(3'd3, 1'b0, splat(16'h0100), splat(16'h0100));
    send(3'd3, 1'b0, splat(16'h0100), splat(16'h0100));
    rst = 1'b1;
    exp_res_q.delete(); exp_flg_q.delete();
    for (int i = 0; i < LANES; i++) macc[i] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_flags", flags, 0);
    check("midrst_result", result, 0);
    @(posedge clk); #1;
    obs_res.delete(); obs_flg.delete();
    send(3'd3, 1'b0, splat(16'h0100), splat(16'h0100));
    drain();
    check("midrst_mac", obs_res[0], splat(16'h0100));
    check("midrst_mac_flg", obs_flg[0], 0);

    fork
      begin
        for (int k = 0; k < 300; k++) begin
          send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, {$urandom, $urandom});
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
